// File: rtl/sdram_reader_pkg.sv
// Shared types and constants for the SDRAM frame reader.
package sdram_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_DATA_W = 16;

  // s1 byteenable is active-low; all bytes are always enabled for reads.
  localparam logic [1:0] BYTEEN_N_ALL = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: pop_data always shows the head entry.
// Pushes when full and pops when empty are ignored.
module sync_fifo_fwft #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    do_push  = push & (count_q != (AW+1)'(DEPTH));
    do_pop   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer/count registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM read master streaming a frame from SDRAM into a FWFT FIFO.
// Optional continuous frame refresh: define SDRAM_READER_LOOP_EN.
module sdram_frame_reader
  import sdram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [1:0]        avm_byteenable_n,
  output logic              avm_chipselect,
  output logic              avm_read_n,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              req_q, req_d;
  logic              stop_pend_q, stop_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SDRAM_READER_LOOP_EN
  logic [ADDR_W-1:0] base_lat_q, base_lat_d;
  logic [CNT_W-1:0]  cnt_lat_q, cnt_lat_d;
  logic [CNT_W-1:0]  rx_rem_q, rx_rem_d;
  logic              frame_pulse;
`endif

  logic          accept, rx_en, push, pop, hold_req, last_accept, stop_now, credit_ok;
  logic          fifo_empty, fifo_full;
  logic [OW-1:0] fifo_count, fcnt_next;
  logic [OW:0]   credit_sum;

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push),
    .push_data (avm_readdata),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Handshake decode and credit. Credit uses next-cycle occupancy so the
  // registered request drops exactly when FIFO plus in-flight words fill up.
  always_comb begin
    accept      = req_q & ~avm_waitrequest;
    rx_en       = avm_readdatavalid & ((state_q == ISSUE) | (state_q == DRAIN));
    push        = rx_en & ~fifo_full;
    pop         = ~fifo_empty & out_ready;
    outst_d     = outst_q + OW'(accept) - OW'(rx_en);
    fcnt_next   = fifo_count + OW'(push) - OW'(pop);
    credit_sum  = {1'b0, fcnt_next} + {1'b0, outst_d};
    credit_ok   = credit_sum < (OW+1)'(FIFO_DEPTH);
    hold_req    = req_q & avm_waitrequest;
    last_accept = accept & (rem_q == CNT_W'(1));
    stop_now    = stop | stop_pend_q;
  end

  // Control FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_d       = req_q;
    stop_pend_d = stop_pend_q;
`ifdef SDRAM_READER_LOOP_EN
    base_lat_d  = base_lat_q;
    cnt_lat_d   = cnt_lat_q;
    rx_rem_d    = rx_rem_q;
    frame_pulse = rx_en & (rx_rem_q == CNT_W'(1));
    if (rx_en) begin
      rx_rem_d = (rx_rem_q == CNT_W'(1)) ? cnt_lat_q : rx_rem_q - CNT_W'(1);
    end
`endif
    if (accept) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        req_d       = 1'b0;
        stop_pend_d = 1'b0;
        if (start) begin
          if (word_count != '0) begin
            state_d = ISSUE;
            addr_d  = base_addr;
            rem_d   = word_count;
            req_d   = 1'b1;
`ifdef SDRAM_READER_LOOP_EN
            base_lat_d = base_addr;
            cnt_lat_d  = word_count;
            rx_rem_d   = word_count;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
`ifdef SDRAM_READER_LOOP_EN
        if (last_accept) begin
          addr_d = base_lat_q;
          rem_d  = cnt_lat_q;
        end
`endif
        // A stop seen while a request is stalled is remembered so the
        // presented request stays stable until the slave takes it.
        if (stop_now && !hold_req) begin
          state_d     = DRAIN;
          req_d       = 1'b0;
          stop_pend_d = 1'b0;
        end else if (stop_now) begin
          stop_pend_d = 1'b1;
`ifndef SDRAM_READER_LOOP_EN
        end else if (last_accept) begin
          state_d = DRAIN;
          req_d   = 1'b0;
`endif
        end else begin
          req_d = hold_req | credit_ok;
        end
      end
      DRAIN: begin
        req_d = 1'b0;
        if ((outst_d == '0) && (fcnt_next == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ISSUE) | (state_d == DRAIN);
`ifdef SDRAM_READER_LOOP_EN
    done_d = (state_d == DONE) | frame_pulse;
`else
    done_d = (state_d == DONE);
`endif
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      outst_q     <= '0;
      req_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SDRAM_READER_LOOP_EN
      base_lat_q  <= '0;
      cnt_lat_q   <= '0;
      rx_rem_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      outst_q     <= outst_d;
      req_q       <= req_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SDRAM_READER_LOOP_EN
      base_lat_q  <= base_lat_d;
      cnt_lat_q   <= cnt_lat_d;
      rx_rem_q    <= rx_rem_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign avm_address      = addr_q;
  assign avm_chipselect   = req_q;
  assign avm_read_n       = ~req_q;
  assign avm_byteenable_n = BYTEEN_N_ALL;
  assign avm_write_n      = 1'b1;
  assign avm_writedata    = '0;
  assign out_valid        = ~fifo_empty;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Self-checking bench for sdram_frame_reader with a behavioural s1 slave.
module tb_sdram_frame_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        start, stop;
  logic [23:0] base_addr, word_count;
  logic        busy, done;
  logic [23:0] avm_address;
  logic [1:0]  avm_byteenable_n;
  logic        avm_chipselect, avm_read_n, avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest;
  logic [15:0] out_data;
  logic        out_valid, out_ready;

  int total = 0;
  int bad   = 0;

  // Slave/monitor state
  int          cyc = 0;
  int          lat = 1;
  bit          sh_v [8];
  logic [23:0] sh_a [8];
  logic [23:0] acc_q [$];
  logic [15:0] rx_q [$];
  int          done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, start_cyc = 0;
  bit          valid_seen = 0;

  sdram_frame_reader #(
    .ADDR_W     (24),
    .DATA_W     (16),
    .FIFO_DEPTH (16),
    .CNT_W      (24)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .start             (start),
    .stop              (stop),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_byteenable_n  (avm_byteenable_n),
    .avm_chipselect    (avm_chipselect),
    .avm_read_n        (avm_read_n),
    .avm_write_n       (avm_write_n),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [15:0] fdat(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int addr_errs(input logic [23:0] b);
    int e = 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i] !== 24'(b + 24'(i))) e++;
    return e;
  endfunction

  function automatic int data_errs(input logic [23:0] b);
    int e = 0;
    for (int i = 0; i < rx_q.size(); i++)
      if (rx_q[i] !== fdat(24'(b + 24'(i)))) e++;
    return e;
  endfunction

  // s1 slave and stream monitor: sample pre-edge values, answer after the edge.
  initial begin : slave
    bit          acc_v;
    logic [23:0] a_v;
    forever begin
      @(posedge clk_clk);
      cyc++;
      acc_v = avm_chipselect && !avm_read_n && !avm_waitrequest;
      a_v   = avm_address;
      if (acc_v) acc_q.push_back(a_v);
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start) start_cyc = cyc;
      if (out_valid) valid_seen = 1;
      #1;
      for (int i = 7; i > 0; i--) begin
        sh_v[i] = sh_v[i-1];
        sh_a[i] = sh_a[i-1];
      end
      sh_v[0] = acc_v;
      sh_a[0] = a_v;
      avm_readdatavalid = sh_v[lat];
      avm_readdata      = sh_v[lat] ? fdat(sh_a[lat]) : 16'h0000;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic pulse_start(input logic [23:0] b, input logic [23:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk_clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      if (done_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [23:0] base;
    logic [23:0] count;
    logic [23:0] exp_last;
    int          exp_acc;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    bit          ok;
    int          stable_err;
    logic [23:0] last_a;

    vecs[0] = '{base: 24'h000100, count: 24'd4,  exp_last: 24'h000103, exp_acc: 4};
    vecs[1] = '{base: 24'hFFFFFE, count: 24'd4,  exp_last: 24'h000001, exp_acc: 4};
    vecs[2] = '{base: 24'h123456, count: 24'd1,  exp_last: 24'h123456, exp_acc: 1};
    vecs[3] = '{base: 24'h000000, count: 24'd20, exp_last: 24'h000013, exp_acc: 20};
    vecs[4] = '{base: 24'h000010, count: 24'd0,  exp_last: 24'h000000, exp_acc: 0};

    reset_reset_n   = 1'b0;
    start           = 1'b0;
    stop            = 1'b0;
    base_addr       = '0;
    word_count      = '0;
    avm_waitrequest = 1'b0;
    out_ready       = 1'b0;
    repeat (3) @(negedge clk_clk);

    check("rst_cs",    avm_chipselect, 0);
    check("rst_rdn",   avm_read_n, 1);
    check("rst_addr",  avm_address, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ben",   avm_byteenable_n, 0);
    check("rst_wrn",   avm_write_n, 1);
    check("rst_wdata", avm_writedata, 0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Table of complete frames with free-flowing output.
    for (int r = 0; r < 5; r++) begin
      acc_q.delete();
      rx_q.delete();
      out_ready = 1'b1;
      pulse_start(vecs[r].base, vecs[r].count);
      wait_done(300, ok);
      check($sformatf("r%0d_done", r), ok, 1);
      check($sformatf("r%0d_acc", r), acc_q.size(), vecs[r].exp_acc);
      check($sformatf("r%0d_addrseq", r), addr_errs(vecs[r].base), 0);
      if (vecs[r].exp_acc > 0) begin
        last_a = (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 24'hDEAD00;
        check($sformatf("r%0d_last", r), last_a, vecs[r].exp_last);
        check($sformatf("r%0d_done_after_pop", r), done_cyc, last_pop_cyc + 1);
      end else begin
        check($sformatf("r%0d_done_after_start", r), done_cyc, start_cyc + 1);
      end
      check($sformatf("r%0d_nwords", r), rx_q.size(), vecs[r].count);
      check($sformatf("r%0d_data", r), data_errs(vecs[r].base), 0);
      check($sformatf("r%0d_busy", r), busy, 0);
      check($sformatf("r%0d_done_pulse", r), done, 0);
      @(negedge clk_clk);
    end

    // First-request latency, then waitrequest stall on the second request.
    acc_q.delete();
    rx_q.delete();
    out_ready = 1'b1;
    pulse_start(24'h000100, 24'd4);
    check("lat_cs",   avm_chipselect, 1);
    check("lat_rdn",  avm_read_n, 0);
    check("lat_addr", avm_address, 24'h000100);
    check("lat_busy", busy, 1);
    @(negedge clk_clk);
    avm_waitrequest = 1'b1;
    stable_err = 0;
    for (int k = 0; k < 4; k++) begin
      if (!(avm_chipselect && !avm_read_n && avm_address == 24'h000101)) stable_err++;
      if (k == 3) avm_waitrequest = 1'b0;
      else @(negedge clk_clk);
    end
    check("wr_stable", stable_err, 0);
    check("wr_acc_held", acc_q.size(), 1);
    wait_done(100, ok);
    check("wr_done", ok, 1);
    check("wr_acc", acc_q.size(), 4);
    check("wr_addrseq", addr_errs(24'h000100), 0);
    check("wr_data", data_errs(24'h000100), 0);
    @(negedge clk_clk);

    // Backpressure: credit limits requests to the FIFO depth.
    acc_q.delete();
    rx_q.delete();
    out_ready = 1'b0;
    pulse_start(24'h000400, 24'd40);
    repeat (60) @(negedge clk_clk);
    check("bp_acc16", acc_q.size(), 16);
    check("bp_cs",    avm_chipselect, 0);
    check("bp_valid", out_valid, 1);
    check("bp_head",  out_data, fdat(24'h000400));
    check("bp_busy",  busy, 1);
    out_ready = 1'b1;
    wait_done(400, ok);
    check("bp_done",  ok, 1);
    check("bp_acc",   acc_q.size(), 40);
    check("bp_words", rx_q.size(), 40);
    check("bp_data",  data_errs(24'h000400), 0);
    @(negedge clk_clk);

    // A start while busy is ignored.
    acc_q.delete();
    rx_q.delete();
    pulse_start(24'h000500, 24'd8);
    repeat (2) @(negedge clk_clk);
    pulse_start(24'h000700, 24'd3);
    wait_done(200, ok);
    check("ign_done", ok, 1);
    check("ign_acc",  acc_q.size(), 8);
    check("ign_addr", addr_errs(24'h000500), 0);
    repeat (5) @(negedge clk_clk);
    check("ign_no_restart", busy, 0);

    // Stop coinciding with an acceptance: that word still counts and drains.
    acc_q.delete();
    rx_q.delete();
    pulse_start(24'h000800, 24'd30);
    repeat (5) @(negedge clk_clk);
    stop = 1'b1;
    @(negedge clk_clk);
    stop = 1'b0;
    wait_done(100, ok);
    check("stop_done",  ok, 1);
    check("stop_acc",   acc_q.size(), 6);
    check("stop_words", rx_q.size(), 6);
    check("stop_data",  data_errs(24'h000800), 0);
    @(negedge clk_clk);

    // Reset during ISSUE with three reads in flight; late data is discarded.
    acc_q.delete();
    rx_q.delete();
    lat = 5;
    out_ready = 1'b1;
    pulse_start(24'h000200, 24'd10);
    repeat (3) @(negedge clk_clk);
    check("mr_inflight", acc_q.size(), 3);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    check("mr_cs",    avm_chipselect, 0);
    check("mr_rdn",   avm_read_n, 1);
    check("mr_addr",  avm_address, 0);
    check("mr_busy",  busy, 0);
    check("mr_done",  done, 0);
    check("mr_valid", out_valid, 0);
    reset_reset_n = 1'b1;
    valid_seen = 0;
    repeat (15) @(negedge clk_clk);
    check("mr_late_valid", valid_seen, 0);
    check("mr_words",      rx_q.size(), 0);
    check("mr_idle_busy",  busy, 0);
    check("mr_idle_cs",    avm_chipselect, 0);
    lat = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
